// File: rtl/ir_nec_tx.sv
// ir_nec_tx
// NEC-protocol infrared transmitter. A command word accepted over valid/ready
// is sent as leader (16 mark + 8 space units), DATA_BITS pulse-distance bits
// LSB first (1 mark + 1 or 3 space units), and a 1-unit stop mark. The frame
// is padded with space to SLOT_UNITS units. While hold is high at a slot end,
// an NEC repeat code (16 mark, 4 space, 1 mark, pad) fills the next slot.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   cmd          command word, latched on accept
//   valid        command request
//   hold         repeat request, sampled only at slot end
//   ready        high only while idle
//   ir_output    envelope gated by carrier (or the envelope when CARRIER_EN=0)
//   ir_envelope  unmodulated mark/space envelope
//   frame_done   one-cycle pulse at the end of every slot
//   fsm_state    current FSM state, for observation
//
// Handshake: a command is accepted on a clk edge where valid & ready are both
// high. ready is high only in IDLE, so valid outside IDLE is ignored and cmd
// is not looked at again until the next accept.
module ir_nec_tx #(
  parameter int DATA_BITS    = 32,
  parameter int TICK_CYC     = 14063,
  parameter int CARRIER_HALF = 329,
  parameter int CARRIER_EN   = 1,
  parameter int SLOT_UNITS   = 192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] cmd,
  input  logic                 valid,
  input  logic                 hold,
  output logic                 ready,
  output logic                 ir_output,
  output logic                 ir_envelope,
  output logic                 frame_done,
  output logic [3:0]           fsm_state
);

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE,
    STOP_MARK, GAP, REP_MARK, REP_SPACE, REP_STOP
  } state_t;

  localparam int CYC_W  = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int SLOT_W = $clog2(SLOT_UNITS + 1);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CAR_W  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_UNITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(SLOT_UNITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_HALF - 1);

  state_t               state, state_n;
  logic [CYC_W-1:0]     cyc_cnt;
  logic [4:0]           unit_cnt;
  logic [SLOT_W-1:0]    slot_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [CAR_W-1:0]     car_cnt, car_n;
  logic                 phase, phase_n;

  logic       unit_tick, last_unit, slot_last;
  logic       accept, slot_end, shift, mark_n;
  logic [4:0] state_units;

  assign fsm_state = state;

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) ||
           (s == REP_MARK)  || (s == REP_STOP);
  endfunction

  always_comb begin
    unit_tick = (state != IDLE) && (cyc_cnt == CYC_LAST);

    case (state)
      LEAD_MARK:  state_units = 5'd16;
      LEAD_SPACE: state_units = 5'd8;
      BIT_SPACE:  state_units = shreg[0] ? 5'd3 : 5'd1;
      REP_MARK:   state_units = 5'd16;
      REP_SPACE:  state_units = 5'd4;
      default:    state_units = 5'd1;
    endcase

    last_unit = unit_tick && (unit_cnt == state_units - 5'd1);
    slot_last = unit_tick && (slot_cnt == SLOT_LAST);

    state_n  = state;
    accept   = 1'b0;
    slot_end = 1'b0;
    shift    = 1'b0;

    case (state)
      IDLE:       if (valid && ready) begin
                    accept  = 1'b1;
                    state_n = LEAD_MARK;
                  end
      LEAD_MARK:  if (last_unit) state_n = LEAD_SPACE;
      LEAD_SPACE: if (last_unit) state_n = BIT_MARK;
      BIT_MARK:   if (last_unit) state_n = BIT_SPACE;
      BIT_SPACE:  if (last_unit) begin
                    shift   = 1'b1;
                    state_n = (bit_cnt == BIT_LAST) ? STOP_MARK : BIT_MARK;
                  end
      REP_MARK:   if (last_unit) state_n = REP_SPACE;
      REP_SPACE:  if (last_unit) state_n = REP_STOP;
      // A frame that exactly fills the slot ends straight from its stop mark.
      STOP_MARK,
      REP_STOP:   if (last_unit) begin
                    if (slot_last) slot_end = 1'b1;
                    else           state_n  = GAP;
                  end
      GAP:        if (slot_last) slot_end = 1'b1;
      default:    state_n = IDLE;
    endcase

    if (slot_end) state_n = hold ? REP_MARK : IDLE;

    mark_n = is_mark(state_n);

    // Carrier restarts high on every entry into a mark state.
    if (mark_n && (state_n != state)) begin
      phase_n = 1'b1;
      car_n   = '0;
    end else if (car_cnt == CAR_LAST) begin
      phase_n = ~phase;
      car_n   = '0;
    end else begin
      phase_n = phase;
      car_n   = car_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      ir_output   <= 1'b0;
      ir_envelope <= 1'b0;
      frame_done  <= 1'b0;
      cyc_cnt     <= '0;
      unit_cnt    <= '0;
      slot_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      car_cnt     <= '0;
      phase       <= 1'b0;
    end else begin
      state       <= state_n;
      ready       <= (state_n == IDLE);
      ir_envelope <= mark_n;
      ir_output   <= (CARRIER_EN != 0) ? (mark_n & phase_n) : mark_n;
      frame_done  <= slot_end;
      phase       <= phase_n;
      car_cnt     <= car_n;

      if (accept) begin
        shreg    <= cmd;
        cyc_cnt  <= '0;
        unit_cnt <= '0;
        slot_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (state != IDLE) cyc_cnt <= unit_tick ? '0 : cyc_cnt + 1'b1;

        if (state_n != state) unit_cnt <= '0;
        else if (unit_tick)   unit_cnt <= unit_cnt + 5'd1;

        // Slot counter saturates so an over-long GAP cannot wrap it.
        if (slot_end)                              slot_cnt <= '0;
        else if (unit_tick && slot_cnt != SLOT_MAX) slot_cnt <= slot_cnt + 1'b1;

        if (shift) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: small timing parameters, two instances (carrier on and
// off) sharing stimulus. Expected per-cycle output words are built from the
// NEC frame description and compared each cycle on the falling edge.
// Word layout: {ready, frame_done, envelope, output, nc_envelope, nc_output}.
module tb_ir_nec_tx;
  localparam int DB   = 8;
  localparam int TICK = 4;
  localparam int HALF = 1;
  localparam int SLOT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DB-1:0] cmd;
  logic          valid, hold;

  logic       ready, ir_output, ir_envelope, frame_done;
  logic [3:0] fsm_state;
  logic       nc_ready, nc_output, nc_envelope, nc_done;
  logic [3:0] nc_state;

  logic [5:0] exp_q[$];
  bit         pending_done;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  ir_nec_tx #(.DATA_BITS(DB), .TICK_CYC(TICK), .CARRIER_HALF(HALF),
              .CARRIER_EN(1), .SLOT_UNITS(SLOT)) u_dut (
    .clk(clk), .rst(rst), .cmd(cmd), .valid(valid), .hold(hold),
    .ready(ready), .ir_output(ir_output), .ir_envelope(ir_envelope),
    .frame_done(frame_done), .fsm_state(fsm_state));

  ir_nec_tx #(.DATA_BITS(DB), .TICK_CYC(TICK), .CARRIER_HALF(HALF),
              .CARRIER_EN(0), .SLOT_UNITS(SLOT)) u_dut_nc (
    .clk(clk), .rst(rst), .cmd(cmd), .valid(valid), .hold(hold),
    .ready(nc_ready), .ir_output(nc_output), .ir_envelope(nc_envelope),
    .frame_done(nc_done), .fsm_state(nc_state));

  function automatic logic [5:0] observed();
    return {ready, frame_done, ir_envelope, ir_output, nc_envelope, nc_output};
  endfunction

  // ---------------- expected-word generation ----------------
  task automatic push_seg(input bit mark, input int units);
    logic [5:0] w;
    for (int i = 0; i < units * TICK; i++) begin
      w = {1'b0, 1'b0, mark, mark & (((i / HALF) % 2) == 0), mark, mark};
      if (pending_done) begin
        w[4] = 1'b1;
        pending_done = 1'b0;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic push_slot(input bit rep, input logic [DB-1:0] c);
    int used;
    push_seg(1'b1, 16);
    if (rep) begin
      push_seg(1'b0, 4);
      push_seg(1'b1, 1);
      used = 21;
    end else begin
      push_seg(1'b0, 8);
      used = 24;
      for (int b = 0; b < DB; b++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, c[b] ? 3 : 1);
        used += c[b] ? 4 : 2;
      end
      push_seg(1'b1, 1);
      used += 1;
    end
    push_seg(1'b0, SLOT - used);
  endtask

  task automatic push_idle(input bit done);
    exp_q.push_back({1'b1, done, 4'b0000});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] got, exp;
    rst = 1'b0; valid = 1'b0; hold = 1'b0; cmd = '0;
    repeat (3) @(negedge clk);
    got = observed();
    checks++;
    if (got !== 6'b100000) $display("FAIL reset_values: got %b expected %b", got, 6'b100000);
    else passed++;
    checks++;
    if (fsm_state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", fsm_state);
    else passed++;
    rst = 1'b1;
    repeat (20) push_idle(1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      got = observed();
      checks++;
      if (exp_q.size() == 0) $display("FAIL idle cycle %0d: got %b expected queue entry, none", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL idle cycle %0d: got %b expected %b", c, got, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_data_frame();
    logic [5:0] got, exp;
    cmd = 8'hA5; valid = 1'b1; hold = 1'b0;
    push_slot(1'b0, 8'hA5);
    push_idle(1'b1);
    push_idle(1'b0);
    push_idle(1'b0);
    for (int c = 0; c < 259; c++) begin
      @(negedge clk);
      if (c == 0) begin valid = 1'b0; cmd = 8'h00; end
      got = observed();
      checks++;
      if (exp_q.size() == 0) $display("FAIL data_frame cycle %0d: got %b expected queue entry, none", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL data_frame cycle %0d: got %b expected %b", c, got, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_repeat();
    logic [5:0] got, exp;
    cmd = 8'h3C; valid = 1'b1; hold = 1'b1;
    push_slot(1'b0, 8'h3C);
    pending_done = 1'b1;
    push_slot(1'b1, '0);
    pending_done = 1'b1;
    push_slot(1'b1, '0);
    push_idle(1'b1);
    push_idle(1'b0);
    push_idle(1'b0);
    for (int c = 0; c < 771; c++) begin
      @(negedge clk);
      if (c == 0) valid = 1'b0;
      if (c == 600) hold = 1'b0;
      got = observed();
      checks++;
      if (exp_q.size() == 0) $display("FAIL repeat cycle %0d: got %b expected queue entry, none", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL repeat cycle %0d: got %b expected %b", c, got, exp);
        else passed++;
      end
    end
  endtask

  // New valid/cmd mid-frame: ignored until idle, then accepted on the first
  // idle cycle so the second frame starts right after the done pulse.
  task automatic test_handshake_abuse();
    logic [5:0] got, exp;
    cmd = 8'hA5; valid = 1'b1; hold = 1'b0;
    push_slot(1'b0, 8'hA5);
    push_idle(1'b1);
    push_slot(1'b0, 8'h3C);
    push_idle(1'b1);
    push_idle(1'b0);
    for (int c = 0; c < 515; c++) begin
      @(negedge clk);
      if (c == 0)   valid = 1'b0;
      if (c == 50)  begin valid = 1'b1; cmd = 8'h3C; end
      if (c == 257) valid = 1'b0;
      if (c == 300) cmd = 8'hFF;
      got = observed();
      checks++;
      if (exp_q.size() == 0) $display("FAIL handshake cycle %0d: got %b expected queue entry, none", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL handshake cycle %0d: got %b expected %b", c, got, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] got, exp;
    cmd = 8'h5A; valid = 1'b1; hold = 1'b0;
    push_slot(1'b0, 8'h5A);
    // Cycles 96..99 are the first BIT_MARK; stop checking at cycle 97.
    for (int c = 0; c < 98; c++) begin
      @(negedge clk);
      if (c == 0) valid = 1'b0;
      got = observed();
      checks++;
      if (exp_q.size() == 0) $display("FAIL rst_mid cycle %0d: got %b expected queue entry, none", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL rst_mid cycle %0d: got %b expected %b", c, got, exp);
        else passed++;
      end
    end
    exp_q.delete();
    #1 rst = 1'b0;
    #1;
    got = observed();
    checks++;
    if (got !== 6'b100000) $display("FAIL rst_async: got %b expected %b", got, 6'b100000);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) push_idle(1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      got = observed();
      checks++;
      if (exp_q.size() == 0) $display("FAIL rst_after cycle %0d: got %b expected queue entry, none", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL rst_after cycle %0d: got %b expected %b", c, got, exp);
        else passed++;
      end
    end
  endtask

  initial begin
    pending_done = 1'b0;
    test_reset();
    test_data_frame();
    test_repeat();
    test_handshake_abuse();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
